// File: rtl/cei_mochila_pkg.sv
// cei_mochila_pkg: system-level defaults and arbiter state encoding
package cei_mochila_pkg;
  localparam int ARB_MAX_OUTSTANDING = 2;
  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_HOLD = 1'b1
  } arb_state_e;
endpackage

// File: rtl/obi_pkg.sv
// obi_pkg: OBI request/response bundles shared by harts and the system bus
package obi_pkg;
  typedef struct packed {
    logic        req;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } obi_req_t;
  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;
endpackage

// File: rtl/obi_core_arbiter_if.sv
// obi_core_arbiter_if: per-hart request/response vectors plus the merged bus port
import obi_pkg::*;
interface obi_core_arbiter_if #(
  parameter int NHARTS = 3
);
  obi_req_t  [NHARTS-1:0] core_req_i;
  obi_resp_t [NHARTS-1:0] core_resp_o;
  obi_req_t               bus_req_o;
  obi_resp_t              bus_resp_i;
  modport slave (input core_req_i, bus_resp_i, output core_resp_o, bus_req_o);
  modport master (output core_req_i, bus_resp_i, input core_resp_o, bus_req_o);
endinterface

// File: rtl/obi_id_fifo.sv
// obi_id_fifo: in-order queue of granted hart indices awaiting rvalid
module obi_id_fifo #(
  parameter int W     = 2,
  parameter int DEPTH = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic [W-1:0]               data_i,
  input  logic                       pop_i,
  output logic [W-1:0]               data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);
  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;
  assign full_o  = cnt_q == CW'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign count_o = cnt_q;
  assign data_o  = mem_q[rd_q];
  assign do_push = push_i & (~full_o | pop_i);
  assign do_pop  = pop_i & ~empty_o;
  // pointer wrap and occupancy bookkeeping
  always_comb begin
    wr_d  = do_push ? (wr_q == PW'(DEPTH-1) ? '0 : wr_q + PW'(1)) : wr_q;
    rd_d  = do_pop ? (rd_q == PW'(DEPTH-1) ? '0 : rd_q + PW'(1)) : rd_q;
    cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
  end
  // storage needs no reset: entries are only read while counted valid
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end
  // pointers and count clear asynchronously so in-flight IDs are forgotten
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/obi_core_arbiter.sv
// obi_core_arbiter: round-robin merge of hart OBI ports with in-order response routing
module obi_core_arbiter
  import obi_pkg::*;
  import cei_mochila_pkg::*;
#(
  parameter int NHARTS          = 3,
  parameter int MAX_OUTSTANDING = ARB_MAX_OUTSTANDING
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  obi_core_arbiter_if.slave                    bus,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_o,
  output logic                                 protocol_err_o
);
  localparam int IW = NHARTS > 1 ? $clog2(NHARTS) : 1;
  arb_state_e      state_q, state_d;
  logic [IW-1:0]   latched_q, latched_d, rr_q, rr_d;
  logic [IW-1:0]   winner, sel, head;
  logic            err_q, any_req, active, push, pop, full, empty;
  logic [NHARTS-1:0] req_vec;
  int              idx;
  obi_req_t        fwd;
  // first requesting hart at or after rr_q, scanning backwards so the nearest wins
  always_comb begin
    winner = rr_q;
    idx    = 0;
    for (int k = 0; k < NHARTS; k++) req_vec[k] = bus.core_req_i[k].req;
    for (int k = NHARTS-1; k >= 0; k--) begin
      idx = (int'(rr_q) + k) % NHARTS;
      if (req_vec[idx]) winner = IW'(idx);
    end
  end
  assign any_req = |req_vec;
  assign sel     = state_q == ARB_HOLD ? latched_q : winner;
  assign active  = state_q == ARB_HOLD | (any_req & ~full);
  assign push    = active & bus.bus_resp_i.gnt;
  assign pop     = bus.bus_resp_i.rvalid & ~empty;
  // forward the selected hart; a held request stays pinned for address stability
  always_comb begin
    fwd           = bus.core_req_i[sel];
    fwd.req       = 1'b1;
    bus.bus_req_o = active ? fwd : '0;
  end
  // gnt to the selected hart only, rvalid to the FIFO head only, rdata broadcast
  always_comb begin
    for (int i = 0; i < NHARTS; i++) begin
      bus.core_resp_o[i].gnt    = push & (sel == IW'(i));
      bus.core_resp_o[i].rvalid = pop & (head == IW'(i));
      bus.core_resp_o[i].rdata  = bus.bus_resp_i.rdata;
    end
  end
  // IDLE/HOLD transitions, winner latch and round-robin pointer advance
  always_comb begin
    state_d   = state_q == ARB_IDLE ? (active & ~bus.bus_resp_i.gnt ? ARB_HOLD : ARB_IDLE)
                                    : (bus.bus_resp_i.gnt ? ARB_IDLE : ARB_HOLD);
    latched_d = state_q == ARB_IDLE & active & ~bus.bus_resp_i.gnt ? winner : latched_q;
    rr_d      = push ? (sel == IW'(NHARTS-1) ? '0 : sel + IW'(1)) : rr_q;
  end
  // arbitration state and sticky protocol error
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ARB_IDLE;
      latched_q <= '0;
      rr_q      <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      latched_q <= latched_d;
      rr_q      <= rr_d;
      err_q     <= err_q | (bus.bus_resp_i.rvalid & empty);
    end
  end
  assign protocol_err_o = err_q;
  obi_id_fifo #(
    .W    (IW),
    .DEPTH(MAX_OUTSTANDING)
  ) u_id_fifo (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .push_i (push),
    .data_i (sel),
    .pop_i  (pop),
    .data_o (head),
    .full_o (full),
    .empty_o(empty),
    .count_o(outstanding_o)
  );
endmodule

// File: tb/tb_obi_core_arbiter.sv
// tb_obi_core_arbiter: directed checks of arbitration, hold, full, stray rvalid and reset
module tb_obi_core_arbiter;
  import obi_pkg::*;
  logic       clk_i = 1'b0;
  logic       rst_i;
  logic [1:0] outstanding_o;
  logic       protocol_err_o;
  int         n_chk = 0;
  int         n_pass = 0;
  obi_core_arbiter_if #(.NHARTS(3)) bus_if ();
  obi_core_arbiter #(.NHARTS(3), .MAX_OUTSTANDING(2)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .bus           (bus_if),
    .outstanding_o (outstanding_o),
    .protocol_err_o(protocol_err_o)
  );
  always #5 clk_i = ~clk_i;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask
  task automatic hreq(input int h, input logic [31:0] a, input logic [31:0] w, input logic we);
    bus_if.core_req_i[h].req   = 1'b1;
    bus_if.core_req_i[h].addr  = a;
    bus_if.core_req_i[h].we    = we;
    bus_if.core_req_i[h].be    = 4'hF;
    bus_if.core_req_i[h].wdata = w;
  endtask
  function automatic logic [2:0] gv();
    for (int i = 0; i < 3; i++) gv[i] = bus_if.core_resp_o[i].gnt;
  endfunction
  function automatic logic [2:0] rv();
    for (int i = 0; i < 3; i++) rv[i] = bus_if.core_resp_o[i].rvalid;
  endfunction
  initial begin
    rst_i = 1'b1;
    bus_if.core_req_i  = '0;
    bus_if.bus_resp_i  = '0;
    cyc();
    cyc();
    chk("rst_outst", outstanding_o, 0);
    chk("rst_err", protocol_err_o, 0);
    chk("rst_busreq", bus_if.bus_req_o.req, 0);
    chk("rst_gnt", gv(), 0);
    chk("rst_rv", rv(), 0);
    rst_i = 1'b0;
    hreq(1, 32'h1000, 32'h0, 1'b0);
    bus_if.bus_resp_i.gnt = 1'b1;
    #1;
    chk("t1_addr", bus_if.bus_req_o.addr, 32'h1000);
    chk("t1_gnt", gv(), 3'b010);
    chk("t1_out0", outstanding_o, 0);
    cyc();
    chk("t1_out1", outstanding_o, 1);
    bus_if.core_req_i = '0;
    bus_if.bus_resp_i.gnt = 1'b0;
    bus_if.bus_resp_i.rvalid = 1'b1;
    bus_if.bus_resp_i.rdata = 32'hCAFE0001;
    #1;
    chk("t1_rv", rv(), 3'b010);
    chk("t1_rdata", bus_if.core_resp_o[1].rdata, 32'hCAFE0001);
    cyc();
    bus_if.bus_resp_i.rvalid = 1'b0;
    chk("t1_out2", outstanding_o, 0);
    rst_i = 1'b1;
    cyc();
    rst_i = 1'b0;
    for (int h = 0; h < 3; h++) hreq(h, 32'h2000 + h * 16, 32'h0, 1'b0);
    bus_if.bus_resp_i.gnt = 1'b1;
    for (int c = 0; c < 6; c++) begin
      bus_if.bus_resp_i.rvalid = c > 0;
      #1;
      chk("rr_gnt", gv(), 64'(1 << (c % 3)));
      chk("rr_rv", rv(), c > 0 ? 64'(1 << ((c - 1) % 3)) : 64'h0);
      chk("rr_addr", bus_if.bus_req_o.addr, 64'(32'h2000 + (c % 3) * 16));
      cyc();
    end
    bus_if.core_req_i = '0;
    bus_if.bus_resp_i.gnt = 1'b0;
    #1;
    chk("rr_rv_last", rv(), 3'b100);
    cyc();
    bus_if.bus_resp_i.rvalid = 1'b0;
    chk("rr_out", outstanding_o, 0);
    hreq(2, 32'h3000, 32'h22222222, 1'b1);
    #1;
    chk("hold_addr0", bus_if.bus_req_o.addr, 32'h3000);
    cyc();
    hreq(0, 32'h3100, 32'h11111111, 1'b1);
    for (int k = 0; k < 2; k++) begin
      #1;
      chk("hold_addr", bus_if.bus_req_o.addr, 32'h3000);
      chk("hold_wdata", bus_if.bus_req_o.wdata, 32'h22222222);
      chk("hold_gnt", gv(), 0);
      cyc();
    end
    bus_if.bus_resp_i.gnt = 1'b1;
    #1;
    chk("hold_gnt2", gv(), 3'b100);
    chk("hold_addr3", bus_if.bus_req_o.addr, 32'h3000);
    cyc();
    bus_if.core_req_i[2] = '0;
    #1;
    chk("hold_gnt0", gv(), 3'b001);
    chk("hold_addr4", bus_if.bus_req_o.addr, 32'h3100);
    cyc();
    chk("hold_out", outstanding_o, 2);
    hreq(1, 32'h4000, 32'h0, 1'b0);
    #1;
    chk("full_req", bus_if.bus_req_o.req, 0);
    chk("full_gnt", gv(), 0);
    cyc();
    chk("full_out", outstanding_o, 2);
    bus_if.bus_resp_i.rvalid = 1'b1;
    #1;
    chk("full_rv", rv(), 3'b100);
    chk("full_gnt2", gv(), 0);
    cyc();
    chk("full_out1", outstanding_o, 1);
    #1;
    chk("pp_gnt", gv(), 3'b010);
    chk("pp_rv", rv(), 3'b001);
    cyc();
    chk("pp_out", outstanding_o, 1);
    bus_if.core_req_i = '0;
    bus_if.bus_resp_i.gnt = 1'b0;
    #1;
    chk("pp_rv_last", rv(), 3'b010);
    cyc();
    chk("pp_out0", outstanding_o, 0);
    chk("pre_err", protocol_err_o, 0);
    #1;
    chk("stray_rv", rv(), 0);
    cyc();
    bus_if.bus_resp_i.rvalid = 1'b0;
    chk("stray_err", protocol_err_o, 1);
    cyc();
    chk("stray_err2", protocol_err_o, 1);
    hreq(0, 32'h5000, 32'h0, 1'b0);
    bus_if.bus_resp_i.gnt = 1'b1;
    cyc();
    cyc();
    bus_if.core_req_i = '0;
    bus_if.bus_resp_i.gnt = 1'b0;
    chk("rm_out2", outstanding_o, 2);
    #2;
    rst_i = 1'b1;
    #1;
    chk("rm_out_async", outstanding_o, 0);
    chk("rm_err_clr", protocol_err_o, 0);
    cyc();
    rst_i = 1'b0;
    bus_if.bus_resp_i.rvalid = 1'b1;
    #1;
    chk("rm_rv", rv(), 0);
    cyc();
    bus_if.bus_resp_i.rvalid = 1'b0;
    chk("rm_err", protocol_err_o, 1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
